mem_arbiter: RTL
================

# mem_arbiter

Shares one slow-memory port between the I-cache and D-cache miss/write-back interfaces, so the chip top can drive a single external memory instead of separate instruction and data memories. It sits between the two `cache` instances and the memory. Each cache keeps its existing memory handshake: hold `mem_read` or `mem_write` plus address and data stable until `mem_ready` pulses. Arbitration is round-robin at transaction granularity, and every transaction ends with a one-cycle release gap.

## Interface
- ADDR_W, 28, block address width (byte address bits [31:4])
- DATA_W, 128, line width
- clk  in  1  clock, all state updates on rising edge
- proc_reset  in  1  synchronous, active-high reset
- i_mem_read  in  1  I-cache read request
- i_mem_write  in  1  I-cache write request (tied 0 in current chip, still arbitrated)
- i_mem_addr  in  ADDR_W  I-cache block address
- i_mem_wdata  in  DATA_W  I-cache write line
- i_mem_rdata  out  DATA_W  read line to I-cache
- i_mem_ready  out  1  completion pulse to I-cache
- d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready: same as i_* for the D-cache
- mem_read  out  1  read strobe to memory
- mem_write  out  1  write strobe to memory
- mem_addr  out  ADDR_W  address to memory
- mem_wdata  out  DATA_W  write line to memory
- mem_rdata  in  DATA_W  read line from memory
- mem_ready  in  1  memory completion, one-cycle pulse
- grant_i  out  1  state is GRANT_I
- grant_d  out  1  state is GRANT_D

## Operation
- States: IDLE, GRANT_I, GRANT_D, RELEASE. Registers: `state` and `last` (last served side, 0=I, 1=D).
- Request per side: req_x = x_mem_read | x_mem_write.
- Transitions out of IDLE:
  - neither side requests: stay in IDLE.
  - only one side requests: go to that side's GRANT.
  - both request: grant the side not equal to `last`.
- On entering a GRANT state, update `last` to that side.
- In GRANT_x, stay until mem_ready=1, then go to RELEASE.
- RELEASE always returns to IDLE after one cycle.
- Memory outputs in GRANT_x are a combinational pass-through of side x: mem_read, mem_write, mem_addr, mem_wdata.
- Memory outputs in IDLE and RELEASE: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- If a granted side asserts both read and write, pass both through unchanged; protocol checking is not this block's job.
- x_mem_ready = mem_ready & (state==GRANT_x). The non-granted side always sees ready=0.
- x_mem_rdata = mem_rdata when state==GRANT_x, else 0.
- If the granted side drops its request before mem_ready, the arbiter stays in GRANT_x with strobes at 0 and waits for mem_ready. The memory contract forbids abandoning a transaction, so no timeout exists.
- A mem_ready arriving in IDLE or RELEASE is ignored and forwarded to nobody.

## Timing
- Reset (proc_reset=1 at a clock edge) sets state=IDLE and last=I. The first tie therefore goes to D.
- Outputs after reset: all mem_* strobes 0, mem_addr/mem_wdata 0, both ready 0, both rdata 0, grant_i/grant_d 0.
- Reset asserted mid-transaction aborts immediately to IDLE. The memory is reset alongside, so no completion is owed.
- Request latency: a request seen in IDLE at edge t produces a strobe on the memory port in cycle t+1. This adds one cycle over a direct connection.
- Completion: mem_ready in cycle k reaches the granted cache in the same cycle k, combinationally.
- After completion: cycle k+1 is RELEASE, cycle k+2 is IDLE, and the earliest next strobe is k+3.
- The RELEASE gap covers the cycle in which a cache still shows its old request after seeing ready. Without it, that stale request would be re-granted.
- Back-to-back requests from the same side, with the other side idle, are served every transaction with the same 2-cycle gap.
- With both sides continuously requesting, grants strictly alternate: D, I, D, I…
- Combinational paths: mem_ready→x_mem_ready, x_mem_*→mem_*, mem_rdata→x_mem_rdata. No path from any input to `state` bypasses the register.

## Test plan
- Lone I read: I-cache requests 0x0000010 at t=0; memory answers ready at t=5 with line 0xA5..A5 → mem_read=1, mem_addr=0x0000010 during t=1..5; i_mem_ready=1 and i_mem_rdata=0xA5..A5 at t=5 only; d_mem_ready stays 0; IDLE at t=7.
- Simultaneous first requests: both sides request right after reset → D granted first (grant_d=1 at t=1); after D completes, I granted exactly 3 cycles after D's ready.
- Sustained contention: both sides hold requests for 6 transactions → grant order D,I,D,I,D,I; no side ever served twice in a row while the other waits.
- Write pass-through: D writes line 0x1234…CDEF to addr 0x00000FF → mem_write=1, mem_wdata and mem_addr match exactly; mem_read=0 throughout; i side never sees ready.
- Stale-request guard: a cache holds its request one cycle after ready → RELEASE keeps mem_read=0, and no second transaction starts for the same address.
- Reset mid-transaction: assert proc_reset while in GRANT_I → next cycle state=IDLE, all outputs 0; a following tie grants D.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory port between I- and D-cache with round-robin per transaction and a one-cycle release gap.
// Grant is one cycle after the request is sampled; mem_ready, data and strobes pass through combinationally.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_i,
    output logic              grant_d
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;   // last served side: 0 = I, 1 = D
    logic   req_i, req_d;

    assign req_i = i_mem_read | i_mem_write;
    assign req_d = d_mem_read | d_mem_write;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req_i && req_d) begin
                    state_d = last_q ? GRANT_I : GRANT_D;
                    last_d  = ~last_q;
                end else if (req_i) begin
                    state_d = GRANT_I;
                    last_d  = 1'b0;
                end else if (req_d) begin
                    state_d = GRANT_D;
                    last_d  = 1'b1;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // The non-granted side and the IDLE/RELEASE cycles see an all-zero port.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_mem_ready = 1'b0;
        i_mem_rdata = '0;
        d_mem_ready = 1'b0;
        d_mem_rdata = '0;
        case (state_q)
            GRANT_I: begin
                mem_read    = i_mem_read;
                mem_write   = i_mem_write;
                mem_addr    = i_mem_addr;
                mem_wdata   = i_mem_wdata;
                i_mem_ready = mem_ready;
                i_mem_rdata = mem_rdata;
            end
            GRANT_D: begin
                mem_read    = d_mem_read;
                mem_write   = d_mem_write;
                mem_addr    = d_mem_addr;
                mem_wdata   = d_mem_wdata;
                d_mem_ready = mem_ready;
                d_mem_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

    assign grant_i = (state_q == GRANT_I);
    assign grant_d = (state_q == GRANT_D);

endmodule
